// File: rtl/ex_stage_ctl_pkg.sv
// Shared definitions for the execute-stage pipeline control: FSM state
// encodings, default counter width and the latency classes ID uses to
// derive the EX latency of an instruction.
package ex_stage_ctl_pkg;

    localparam int EX_CNT_W = 6;

    // Latency classes (EX cycles) offered by ID on id_op_cycles_i
    localparam int EX_LAT_ALU = 1;
    localparam int EX_LAT_MUL = 3;
    localparam int EX_LAT_DIV = 33;

    typedef enum logic [1:0] {
        EX_S_IDLE  = 2'd0,  // no instruction held
        EX_S_BUSY  = 2'd1,  // valid, latency counter still running
        EX_S_READY = 2'd2   // valid, result complete, waiting on MEM
    } ex_state_e;

endpackage

// File: rtl/ex_stage_ctl.sv
// Execute-stage pipeline control. Consumes the ID->EX handshake, holds the
// instruction for its latency (1 cycle ALU, N cycles mul/div), and offers it
// to MEM with back-pressure and flush.
//
// Handshake: an instruction moves ID->EX on a clock edge where
// ctl_id_over_i & ctl_ex_allow_in_o & !ctl_flush_i; it moves EX->MEM on an
// edge where ctl_ex_over_o & ctl_mem_allow_in_i. ctl_ex_allow_in_o depends
// only on registered state and ctl_mem_allow_in_i, never on ctl_id_over_i.
module ex_stage_ctl
    import ex_stage_ctl_pkg::*;
#(
    parameter int CNT_W = EX_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ctl_id_over_i,
    input  logic             id_op_multi_i,
    input  logic [CNT_W-1:0] id_op_cycles_i,
    input  logic             ctl_mem_allow_in_i,
    input  logic             ctl_flush_i,
    output logic             ctl_ex_allow_in_o,
    output logic             ctl_ex_over_o,
    output logic             ex_valid_o,
    output logic             ex_busy_o,
    output logic             ex_start_o,
    output logic             ex_cancel_o
);

    ex_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             start_q, start_d;
    logic             cancel_q, cancel_d;

    logic             cnt_zero;
    logic             accept;
    logic             single_cycle;

    // Handshake outputs derived from registered state and MEM back-pressure
    always_comb begin
        cnt_zero          = (cnt_q == '0);
        ctl_ex_over_o     = valid_q & cnt_zero;
        ctl_ex_allow_in_o = ~valid_q | (ctl_ex_over_o & ctl_mem_allow_in_i);
        ex_busy_o         = valid_q & ~cnt_zero;
        ex_valid_o        = valid_q;
        ex_start_o        = start_q;
        ex_cancel_o       = cancel_q;
        accept            = ctl_id_over_i & ctl_ex_allow_in_o & ~ctl_flush_i;
        single_cycle      = (id_op_cycles_i <= CNT_W'(1));
    end

    // Next-state: flush beats acceptance, acceptance beats retire/countdown
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        start_d  = 1'b0;
        cancel_d = 1'b0;

        if (ctl_flush_i) begin
            state_d  = EX_S_IDLE;
            cnt_d    = '0;
            valid_d  = 1'b0;
            // only an op still counting has a live mul/div unit to abort
            cancel_d = (state_q == EX_S_BUSY);
        end else if (accept) begin
            valid_d = 1'b1;
            if (single_cycle) begin
                cnt_d   = '0;
                state_d = EX_S_READY;
            end else begin
                cnt_d   = id_op_cycles_i - CNT_W'(1);
                state_d = EX_S_BUSY;
                start_d = id_op_multi_i;
            end
        end else begin
            case (state_q)
                EX_S_BUSY: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = EX_S_READY;
                    end
                end
                EX_S_READY: begin
                    if (ctl_mem_allow_in_i) begin
                        state_d = EX_S_IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = EX_S_IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous reset; reset never raises cancel
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= EX_S_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            start_q  <= start_d;
            cancel_q <= cancel_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_ctl.sv
// Bench for ex_stage_ctl: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against an instruction-level
// model (age of the held op versus its latency).
module tb_ex_stage_ctl;

    localparam int W = 6;

    logic         clk;
    logic         rst;
    logic         id_over;
    logic         op_multi;
    logic [W-1:0] op_cycles;
    logic         mem_allow;
    logic         flush;
    logic         allow_in, ex_over, ex_valid, ex_busy, ex_start, ex_cancel;

    int n_vec  = 0;
    int n_fail = 0;

    ex_stage_ctl #(.CNT_W(W)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .ctl_id_over_i      (id_over),
        .id_op_multi_i      (op_multi),
        .id_op_cycles_i     (op_cycles),
        .ctl_mem_allow_in_i (mem_allow),
        .ctl_flush_i        (flush),
        .ctl_ex_allow_in_o  (allow_in),
        .ctl_ex_over_o      (ex_over),
        .ex_valid_o         (ex_valid),
        .ex_busy_o          (ex_busy),
        .ex_start_o         (ex_start),
        .ex_cancel_o        (ex_cancel)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_age: EX cycles spent by the held op (1 in its first cycle)
    // m_lat: cycles it needs (0 and 1 both mean 1)
    bit m_live   = 0;
    bit m_valid  = 0;
    int m_age    = 0;
    int m_lat    = 1;
    bit m_start  = 0;
    bit m_cancel = 0;

    function automatic bit m_over();
        return m_valid && (m_age >= m_lat);
    endfunction

    function automatic bit m_busy();
        return m_valid && (m_age < m_lat);
    endfunction

    function automatic bit m_allow(input bit mem);
        return !m_valid || (m_over() && mem);
    endfunction

    always @(posedge clk) begin
        bit acc, was_busy, retire;
        m_live = 1;
        if (rst) begin
            m_valid  = 0;
            m_age    = 0;
            m_lat    = 1;
            m_start  = 0;
            m_cancel = 0;
        end else begin
            acc      = id_over && m_allow(mem_allow) && !flush;
            was_busy = m_busy();
            retire   = m_over() && mem_allow;
            m_start  = acc && op_multi && (int'(op_cycles) >= 2);
            m_cancel = flush && was_busy;
            if (flush) begin
                m_valid = 0;
            end else if (acc) begin
                m_valid = 1;
                m_age   = 1;
                m_lat   = (int'(op_cycles) < 1) ? 1 : int'(op_cycles);
            end else if (m_valid) begin
                if (retire) m_valid = 0;
                else if (m_age < 100) m_age++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (m_live) begin
            check("allow_in", allow_in,  m_allow(mem_allow));
            check("ex_over",  ex_over,   m_over());
            check("ex_valid", ex_valid,  m_valid);
            check("ex_busy",  ex_busy,   m_busy());
            check("ex_start", ex_start,  m_start);
            check("ex_cancel", ex_cancel, m_cancel);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic io, input logic mu,
                         input int cy, input logic mem, input logic fl);
        @(posedge clk);
        #1;
        rst       = r;
        id_over   = io;
        op_multi  = mu;
        op_cycles = W'(cy);
        mem_allow = mem;
        flush     = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 1, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; id_over = 0; op_multi = 0; op_cycles = '0; mem_allow = 1; flush = 0;

        // reset 3 cycles, then 2 quiet cycles
        for (int i = 0; i < 5; i++) begin
            drive((i < 2) ? 1'b1 : 1'b0, 0, 0, 0, 1, 0);
            @(negedge clk);
            check("rst_allow", allow_in, 1'b1);
            check("rst_over",  ex_over,  1'b0);
            check("rst_valid", ex_valid, 1'b0);
        end

        // three back-to-back single-cycle ops
        drive(0, 1, 0, 1, 1, 0);
        @(negedge clk);
        check("b2b_allow0", allow_in, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(0, 1, 0, 1, 1, 0);
            else idle();
            @(negedge clk);
            check("b2b_over",  ex_over,  1'b1);
            check("b2b_allow", allow_in, 1'b1);
        end
        idle();

        // MUL N=3
        drive(0, 1, 1, 3, 1, 0);
        idle(); @(negedge clk);
        check("mul_c1_start", ex_start, 1'b1);
        check("mul_c1_busy",  ex_busy,  1'b1);
        check("mul_c1_allow", allow_in, 1'b0);
        check("mul_c1_over",  ex_over,  1'b0);
        idle(); @(negedge clk);
        check("mul_c2_start", ex_start, 1'b0);
        check("mul_c2_busy",  ex_busy,  1'b1);
        check("mul_c2_allow", allow_in, 1'b0);
        idle(); @(negedge clk);
        check("mul_c3_over",  ex_over,  1'b1);
        check("mul_c3_busy",  ex_busy,  1'b0);
        idle();

        // MEM stall 4 cycles with a pending offer
        drive(0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 1, 0, 0);
            @(negedge clk);
            check("stall_over",  ex_over,  1'b1);
            check("stall_allow", allow_in, 1'b0);
        end
        drive(0, 1, 0, 1, 1, 0);
        @(negedge clk);
        check("stall_release_allow", allow_in, 1'b1);
        idle(); @(negedge clk);
        check("stall_new_valid", ex_valid, 1'b1);
        check("stall_new_over",  ex_over,  1'b1);
        idle();

        // DIV N=33 flushed in EX cycle 10 while ID offers
        drive(0, 1, 1, 33, 1, 0);
        for (int i = 1; i < 10; i++) idle();
        drive(0, 1, 0, 1, 1, 1);
        @(negedge clk);
        check("div_c10_busy", ex_busy, 1'b1);
        drive(0, 1, 0, 1, 1, 0);
        @(negedge clk);
        check("div_cancel",    ex_cancel, 1'b1);
        check("div_valid_off", ex_valid,  1'b0);
        check("div_allow",     allow_in,  1'b1);
        idle(); @(negedge clk);
        check("div_cancel_once", ex_cancel, 1'b0);
        check("div_late_accept", ex_valid,  1'b1);
        idle();

        // reset in EX cycle 2 of a MUL
        drive(0, 1, 1, 3, 1, 0);
        idle();
        drive(1, 0, 0, 0, 1, 0);
        idle(); @(negedge clk);
        check("rmid_valid",  ex_valid,  1'b0);
        check("rmid_busy",   ex_busy,   1'b0);
        check("rmid_cancel", ex_cancel, 1'b0);
        check("rmid_allow",  allow_in,  1'b1);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            int cy;
            case ($urandom_range(0, 3))
                0: cy = $urandom_range(0, 1);
                1: cy = 3;
                2: cy = $urandom_range(2, 6);
                default: cy = $urandom_range(0, 40);
            endcase
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1),
                  cy,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 24) == 0));
        end
        idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
